// File: rtl/id_interlock_ctrl_if.sv
// Decode-stage interlock bundle: ID/EX fields in, pipeline-register enables out.
interface id_interlock_ctrl_if;
    logic       id_valid;
    logic [0:4] id_r1;
    logic [0:4] id_r2;
    logic       id_usesR2;
    logic       id_mul;
    logic       id_trap;
    logic       ex_MemToReg;
    logic       ex_RegWrite;
    logic [0:4] ex_destReg;
    logic       stall_if;
    logic       stall_id;
    logic       bubble_ex;
    logic       ex_hold;
    logic       mul_busy;
    logic       halt;
    logic [0:1] state;

    modport master (
        output id_valid, id_r1, id_r2, id_usesR2, id_mul, id_trap,
        output ex_MemToReg, ex_RegWrite, ex_destReg,
        input  stall_if, stall_id, bubble_ex, ex_hold, mul_busy, halt, state
    );

    modport slave (
        input  id_valid, id_r1, id_r2, id_usesR2, id_mul, id_trap,
        input  ex_MemToReg, ex_RegWrite, ex_destReg,
        output stall_if, stall_id, bubble_ex, ex_hold, mul_busy, halt, state
    );
endinterface

// File: rtl/id_interlock_ctrl.sv
// Decode-stage interlock: load-use stall, multi-cycle mul occupancy of EX, trap drain then halt.
// Latency: outputs are combinational from registered state/counter and the current ID/EX fields.
// Backpressure: stall_if/stall_id hold the front end; bubble_ex or ex_hold control the ID/EX register.
module id_interlock_ctrl #(
    parameter int unsigned MUL_CYCLES = 6,
    parameter int unsigned TRAP_DRAIN = 3
) (
    input  logic               clk,
    input  logic               reset,
    id_interlock_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        MUL   = 2'b01,
        DRAIN = 2'b10,
        HALT  = 2'b11
    } state_t;

    localparam bit       MUL_MULTI = (MUL_CYCLES > 1);
    localparam logic [7:0] MUL_LOAD  = MUL_MULTI ? 8'(MUL_CYCLES - 2) : 8'd0;
    localparam logic [7:0] TRAP_LOAD = 8'(TRAP_DRAIN - 1);

    state_t     cur_state;
    state_t     nxt_state;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic       live;
    logic       ldhaz;
    logic       stall_if_c;
    logic       stall_id_c;
    logic       bubble_ex_c;
    logic       ex_hold_c;
    logic       mul_busy_c;
    logic       halt_c;

    assign ldhaz = bus.id_valid & bus.ex_MemToReg & bus.ex_RegWrite &
                   (bus.ex_destReg != 5'd0) &
                   ((bus.ex_destReg == bus.id_r1) |
                    (bus.id_usesR2 & (bus.ex_destReg == bus.id_r2)));

    // live stays low through reset and until the first edge after release,
    // so nothing is acted on while the pipe holds no valid instruction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state <= RUN;
            cnt       <= 8'd0;
            live      <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            cnt       <= cnt_nxt;
            live      <= 1'b1;
        end
    end

    always_comb begin
        nxt_state   = cur_state;
        cnt_nxt     = cnt;
        stall_if_c  = 1'b0;
        stall_id_c  = 1'b0;
        bubble_ex_c = 1'b0;
        ex_hold_c   = 1'b0;
        mul_busy_c  = 1'b0;
        halt_c      = 1'b0;
        if (live) begin
            case (cur_state)
                RUN: begin
                    if (bus.id_valid & bus.id_trap) begin
                        stall_if_c  = 1'b1;
                        stall_id_c  = 1'b1;
                        bubble_ex_c = 1'b1;
                        nxt_state   = DRAIN;
                        cnt_nxt     = TRAP_LOAD;
                    end else if (ldhaz) begin
                        stall_if_c  = 1'b1;
                        stall_id_c  = 1'b1;
                        bubble_ex_c = 1'b1;
                    end else if (bus.id_valid & bus.id_mul & MUL_MULTI) begin
                        // issue cycle counts as the first of MUL_CYCLES
                        nxt_state = MUL;
                        cnt_nxt   = MUL_LOAD;
                    end
                end
                MUL: begin
                    stall_if_c = 1'b1;
                    stall_id_c = 1'b1;
                    ex_hold_c  = 1'b1;
                    mul_busy_c = 1'b1;
                    if (cnt == 8'd0) nxt_state = RUN;
                    else             cnt_nxt   = cnt - 8'd1;
                end
                DRAIN: begin
                    stall_if_c  = 1'b1;
                    stall_id_c  = 1'b1;
                    bubble_ex_c = 1'b1;
                    if (cnt == 8'd0) nxt_state = HALT;
                    else             cnt_nxt   = cnt - 8'd1;
                end
                HALT: begin
                    stall_if_c  = 1'b1;
                    stall_id_c  = 1'b1;
                    bubble_ex_c = 1'b1;
                    halt_c      = 1'b1;
                end
                default: nxt_state = RUN;
            endcase
        end
    end

    assign bus.stall_if  = stall_if_c;
    assign bus.stall_id  = stall_id_c;
    assign bus.bubble_ex = bubble_ex_c;
    assign bus.ex_hold   = ex_hold_c;
    assign bus.mul_busy  = mul_busy_c;
    assign bus.halt      = halt_c;
    assign bus.state     = cur_state;

endmodule

// File: tb/tb_id_interlock_ctrl.sv
// Scoreboarded bench for id_interlock_ctrl (MUL_CYCLES=6 main instance, MUL_CYCLES=1 side instance).
module tb_id_interlock_ctrl;

    localparam logic [5:0] O_NONE  = 6'b000000;
    localparam logic [5:0] O_STALL = 6'b111000;
    localparam logic [5:0] O_MUL   = 6'b110110;
    localparam logic [5:0] O_HALT  = 6'b111001;
    localparam logic [1:0] S_RUN   = 2'b00;
    localparam logic [1:0] S_MUL   = 2'b01;
    localparam logic [1:0] S_DRAIN = 2'b10;
    localparam logic [1:0] S_HALT  = 2'b11;

    typedef struct {
        logic [5:0] o;
        logic [1:0] st;
        logic [2:0] m2;
        string      tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_usesR2, id_mul, id_trap, ex_MemToReg, ex_RegWrite;
    logic [0:4] id_r1, id_r2, ex_destReg;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];

    id_interlock_ctrl_if bus6();
    id_interlock_ctrl_if bus1();

    assign bus6.id_valid    = id_valid;
    assign bus6.id_r1       = id_r1;
    assign bus6.id_r2       = id_r2;
    assign bus6.id_usesR2   = id_usesR2;
    assign bus6.id_mul      = id_mul;
    assign bus6.id_trap     = id_trap;
    assign bus6.ex_MemToReg = ex_MemToReg;
    assign bus6.ex_RegWrite = ex_RegWrite;
    assign bus6.ex_destReg  = ex_destReg;

    // side instance never sees a trap so it stays in RUN for the whole run
    assign bus1.id_valid    = id_valid;
    assign bus1.id_r1       = id_r1;
    assign bus1.id_r2       = id_r2;
    assign bus1.id_usesR2   = id_usesR2;
    assign bus1.id_mul      = id_mul;
    assign bus1.id_trap     = 1'b0;
    assign bus1.ex_MemToReg = ex_MemToReg;
    assign bus1.ex_RegWrite = ex_RegWrite;
    assign bus1.ex_destReg  = ex_destReg;

    id_interlock_ctrl #(.MUL_CYCLES(6), .TRAP_DRAIN(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus6)
    );

    id_interlock_ctrl #(.MUL_CYCLES(1), .TRAP_DRAIN(3)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] act_o();
        return {bus6.stall_if, bus6.stall_id, bus6.bubble_ex, bus6.ex_hold, bus6.mul_busy, bus6.halt};
    endfunction

    function automatic logic [2:0] act_m2();
        return {bus1.mul_busy, bus1.state};
    endfunction

    task automatic set_in(input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic u2,
                          input logic mul, input logic trap, input logic mtr, input logic rw,
                          input logic [4:0] dst);
        id_valid    = v;
        id_r1       = r1;
        id_r2       = r2;
        id_usesR2   = u2;
        id_mul      = mul;
        id_trap     = trap;
        ex_MemToReg = mtr;
        ex_RegWrite = rw;
        ex_destReg  = dst;
    endtask

    // one cycle of stimulus; the expectation for that cycle goes to the scoreboard
    task automatic drv(input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic u2,
                       input logic mul, input logic trap, input logic mtr, input logic rw,
                       input logic [4:0] dst, input logic [5:0] o, input logic [1:0] st,
                       input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        set_in(v, r1, r2, u2, mul, trap, mtr, rw, dst);
        e.o   = o;
        e.st  = st;
        e.m2  = 3'b000;
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic idle(input logic [5:0] o, input logic [1:0] st, input string tag);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, o, st, tag);
    endtask

    task automatic chk_now(input string tag, input logic [5:0] o, input logic [1:0] st);
        total++;
        if (act_o() !== o || bus6.state !== st || act_m2() !== 3'b000) begin
            bad++;
            $display("FAIL %s: got o=%b st=%b m2=%b, want o=%b st=%b m2=000",
                     tag, act_o(), bus6.state, act_m2(), o, st);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            total++;
            if (act_o() !== e.o || bus6.state !== e.st || act_m2() !== e.m2) begin
                bad++;
                $display("FAIL %s: got o=%b st=%b m2=%b, want o=%b st=%b m2=%b",
                         e.tag, act_o(), bus6.state, act_m2(), e.o, e.st, e.m2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held with a trap+hazard presented: everything must stay quiet
        reset = 1'b0;
        set_in(1, 5, 0, 0, 0, 1, 1, 1, 5);
        #3 chk_now("reset_hold", O_NONE, S_RUN);
        #9 set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #10 reset = 1'b1;
        #1 chk_now("post_release", O_NONE, S_RUN);

        // load-use on r1, then hazard clears
        drv(1, 5, 0, 0, 0, 0, 1, 1, 5, O_STALL, S_RUN, "ldhaz_r1");
        drv(1, 5, 0, 0, 0, 0, 0, 1, 5, O_NONE,  S_RUN, "ldhaz_clear");
        // r2 gating, dest 0, non-writing load
        drv(1, 1, 7, 0, 0, 0, 1, 1, 7, O_NONE,  S_RUN, "r2_unused");
        drv(1, 1, 7, 1, 0, 0, 1, 1, 7, O_STALL, S_RUN, "r2_used");
        drv(1, 0, 0, 1, 0, 0, 1, 1, 0, O_NONE,  S_RUN, "dest_zero");
        drv(1, 5, 0, 0, 0, 0, 1, 0, 5, O_NONE,  S_RUN, "no_regwrite");
        drv(0, 5, 0, 0, 0, 0, 1, 1, 5, O_NONE,  S_RUN, "id_invalid");

        // single mul: issue cycle, five held cycles, back to RUN
        drv(1, 3, 0, 0, 1, 0, 0, 0, 0, O_NONE, S_RUN, "mul_issue");
        for (int i = 0; i < 5; i++) idle(O_MUL, S_MUL, "mul_busy");
        idle(O_NONE, S_RUN, "mul_done");

        // ldhaz outranks mul issue
        drv(1, 5, 0, 0, 1, 0, 1, 1, 5, O_STALL, S_RUN, "mul_ldhaz");
        drv(1, 5, 0, 0, 1, 0, 0, 0, 5, O_NONE,  S_RUN, "mul_after_haz");
        for (int i = 0; i < 5; i++) idle(O_MUL, S_MUL, "mul2_busy");
        idle(O_NONE, S_RUN, "mul2_done");

        // back-to-back mul, then load-use; ex_* ignored while in MUL
        drv(1, 2, 0, 0, 1, 0, 0, 0, 0, O_NONE, S_RUN, "b2b_first");
        for (int i = 0; i < 5; i++) drv(1, 4, 0, 0, 1, 0, 1, 1, 4, O_MUL, S_MUL, "b2b_wait");
        drv(1, 4, 0, 0, 1, 0, 0, 0, 4, O_NONE, S_RUN, "b2b_second");
        for (int i = 0; i < 5; i++) drv(1, 9, 0, 0, 0, 0, 1, 1, 9, O_MUL, S_MUL, "b2b_busy2");
        drv(1, 9, 0, 0, 0, 0, 1, 1, 9, O_STALL, S_RUN, "b2b_ldhaz");
        drv(1, 9, 0, 0, 0, 0, 0, 1, 9, O_NONE,  S_RUN, "b2b_add_issue");
        idle(O_NONE, S_RUN, "b2b_idle");

        // async reset pulse mid-MUL at cnt=2
        drv(1, 3, 0, 0, 1, 0, 0, 0, 0, O_NONE, S_RUN, "rst_mul_issue");
        idle(O_MUL, S_MUL, "rst_mul_c1");
        idle(O_MUL, S_MUL, "rst_mul_c2");
        @(posedge clk);
        #1 reset = 1'b0;
        #1 chk_now("rst_pulse_low", O_NONE, S_RUN);
        #2 reset = 1'b1;
        #2 chk_now("rst_pulse_after", O_NONE, S_RUN);
        idle(O_NONE, S_RUN, "rst_idle");
        drv(1, 3, 0, 0, 1, 0, 0, 0, 0, O_NONE, S_RUN, "rst_mul2_issue");
        for (int i = 0; i < 5; i++) idle(O_MUL, S_MUL, "rst_mul2_busy");
        idle(O_NONE, S_RUN, "rst_mul2_done");

        // trap together with a load-use: trap wins, drain 3, then halt for good
        drv(1, 5, 0, 0, 0, 1, 1, 1, 5, O_STALL, S_RUN, "trap_issue");
        for (int i = 0; i < 3; i++)
            drv(1, 6, 0, 0, 1, 0, 1, 1, 6, O_STALL, S_DRAIN, "trap_drain");
        for (int i = 0; i < 22; i++)
            drv(1, 5'(i), 5'(i + 1), i[0], i[1], i[2], 1, 1, 5'(i), O_HALT, S_HALT, "halt_hold");

        repeat (2) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
